// File: rtl/chain_code_pkg.sv
// Shared types and constants for the chain-code framer: FSM states, field widths,
// header length and the CRC-8 step used by the optional checksum build.
package chain_code_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_HDR,
        ST_BODY,
        ST_CSUM
    } state_e;

    localparam int unsigned HDR_LEN   = 7;
    localparam int unsigned CODE_W    = 3;
    localparam int unsigned PERIM_W   = 9;
    localparam int unsigned AREA_W    = 12;
    localparam int unsigned COORD_W   = 6;
    localparam logic [7:0]  CRC8_POLY = 8'h07;

    // One byte of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/chain_code_fifo.sv
// Single-clock circular FIFO holding chain codes; pushes when full and pops when
// empty are ignored. Asynchronous active-low reset empties it.
module chain_code_fifo
    import chain_code_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = CODE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/chain_code_framer.sv
// Buffers one contour's chain codes and emits sync/header/codes/checksum as a byte
// stream. Define CHAIN_CODE_FRAMER_CRC8_EN to replace the XOR checksum with CRC-8.
module chain_code_framer
    import chain_code_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 512,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   code_in,
    input  logic         code_valid,
    input  logic         contour_done,
    input  logic [8:0]   perimeter,
    input  logic [11:0]  area,
    input  logic [5:0]   start_x,
    input  logic [5:0]   start_y,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         overflow,
    output logic         len_err
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e               state_q, state_d;
    logic [2:0]           hdr_idx_q, hdr_idx_d;
    logic [7:0]           csum_q, csum_d;
    logic [PERIM_W-1:0]   perim_q, perim_d;
    logic [AREA_W-1:0]    area_q, area_d;
    logic [COORD_W-1:0]   sx_q, sx_d;
    logic [COORD_W-1:0]   sy_q, sy_d;
    logic                 ovf_q, ovf_d;
    logic                 len_err_q, len_err_d;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CODE_W-1:0]    fifo_dout;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        cnt_after;
    logic [7:0]           hdr_byte;
    logic                 xfer;

    function automatic logic [7:0] csum_step(input logic [7:0] c, input logic [7:0] b);
`ifdef CHAIN_CODE_FRAMER_CRC8_EN
        return crc8_update(c, b);
`else
        return c ^ b;
`endif
    endfunction

    chain_code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (fifo_push),
        .din   (code_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy     = (state_q != ST_COLLECT);
    assign overflow = ovf_q;
    assign len_err  = len_err_q;
    assign xfer     = tx_valid && tx_ready;

    always_comb begin
        hdr_byte = '0;
        case (hdr_idx_q)
            3'd0:    hdr_byte = SYNC_BYTE;
            3'd1:    hdr_byte = {2'b0, sx_q};
            3'd2:    hdr_byte = {2'b0, sy_q};
            3'd3:    hdr_byte = {7'b0, perim_q[8]};
            3'd4:    hdr_byte = perim_q[7:0];
            3'd5:    hdr_byte = {4'b0, area_q[11:8]};
            3'd6:    hdr_byte = area_q[7:0];
            default: hdr_byte = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        csum_d    = csum_q;
        perim_d   = perim_q;
        area_d    = area_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        ovf_d     = ovf_q;
        len_err_d = len_err_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        cnt_after = fifo_count + CW'(code_valid && !fifo_full);

        case (state_q)
            ST_COLLECT: begin
                fifo_push = code_valid;
                if (code_valid && fifo_full) ovf_d = 1'b1;
                // Same-cycle code is already included in cnt_after.
                if (contour_done) begin
                    perim_d   = perimeter;
                    area_d    = area;
                    sx_d      = start_x;
                    sy_d      = start_y;
                    hdr_idx_d = '0;
                    if (32'(cnt_after) != 32'(perimeter)) len_err_d = 1'b1;
                    state_d   = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte;
                if (xfer) begin
                    if (hdr_idx_q != 3'd0) csum_d = csum_step(csum_q, hdr_byte);
                    if (hdr_idx_q == 3'(HDR_LEN - 1)) begin
                        state_d = fifo_empty ? ST_CSUM : ST_BODY;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end
            end
            ST_BODY: begin
                tx_valid = 1'b1;
                tx_data  = {5'b0, fifo_dout};
                if (xfer) begin
                    fifo_pop = 1'b1;
                    csum_d   = csum_step(csum_q, {5'b0, fifo_dout});
                    if (fifo_count == CW'(1)) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (xfer) begin
                    csum_d  = '0;
                    state_d = ST_COLLECT;
                end
            end
        endcase

        if (state_q != ST_COLLECT && code_valid) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_COLLECT;
            hdr_idx_q <= '0;
            csum_q    <= '0;
            perim_q   <= '0;
            area_q    <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            ovf_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            csum_q    <= csum_d;
            perim_q   <= perim_d;
            area_q    <= area_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            ovf_q     <= ovf_d;
            len_err_q <= len_err_d;
        end
    end

endmodule

// File: tb/tb_chain_code_framer.sv
// Randomised and directed checks of chain_code_framer against a frame-level byte model.
module tb_chain_code_framer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  code_in = '0;
    logic        code_valid = 1'b0;
    logic        contour_done = 1'b0;
    logic [8:0]  perimeter = '0;
    logic [11:0] area = '0;
    logic [5:0]  start_x = '0;
    logic [5:0]  start_y = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        overflow;
    logic        len_err;

    always #5 clk = ~clk;

    chain_code_framer #(
        .FIFO_DEPTH (DEPTH),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .code_in      (code_in),
        .code_valid   (code_valid),
        .contour_done (contour_done),
        .perimeter    (perimeter),
        .area         (area),
        .start_x      (start_x),
        .start_y      (start_y),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .overflow     (overflow),
        .len_err      (len_err)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic [2:0] code_q[$];
    logic       m_ovf = 1'b0;
    logic       m_len = 1'b0;
    int         ready_mode = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] lit_basic[12] = '{8'hA5, 8'h05, 8'h03, 8'h00, 8'h04, 8'h00,
                                  8'h01, 8'h00, 8'h02, 8'h04, 8'h06, 8'h03};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] ref_csum(input logic [7:0] f[$]);
        logic [7:0] c = '0;
        for (int i = 1; i < f.size(); i++) begin
`ifdef CHAIN_CODE_FRAMER_CRC8_EN
            c = c ^ f[i];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
`else
            c = c ^ f[i];
`endif
        end
        return c;
    endfunction

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
                continue;
            end
            check("busy", busy, exp_q.size() != 0);
            check("tx_valid", tx_valid, exp_q.size() != 0);
            check("overflow", overflow, m_ovf);
            check("len_err", len_err, m_len);
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_data);
            end
            if (tx_valid && exp_q.size() != 0) begin
                check("tx_data", tx_data, exp_q[0]);
                if (tx_ready) begin
                    got.push_back(tx_data);
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(1, 0));
            endcase
        end
    endtask

    task automatic model_push(input logic [2:0] c);
        if (code_q.size() < DEPTH) code_q.push_back(c);
        else m_ovf = 1'b1;
    endtask

    task automatic push_code(input logic [2:0] c);
        code_valid = 1'b1;
        code_in    = c;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        model_push(c);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        code_q.delete();
        m_ovf = 1'b0;
        m_len = 1'b0;
        #1;
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_len_err", len_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_frame(input logic [5:0] sx, input logic [5:0] sy, input logic [8:0] per,
                              input logic [11:0] ar, input logic same_cycle,
                              input logic [2:0] last_code, input logic poke, input int abort_at);
        logic [7:0] f[$];
        int         i;
        contour_done = 1'b1;
        start_x = sx; start_y = sy; perimeter = per; area = ar;
        if (same_cycle) begin
            code_valid = 1'b1;
            code_in    = last_code;
        end
        @(posedge clk);
        #1;
        contour_done = 1'b0;
        code_valid   = 1'b0;
        if (same_cycle) model_push(last_code);
        if (code_q.size() != int'(per)) m_len = 1'b1;
        f = '{8'hA5, {2'b0, sx}, {2'b0, sy}, {7'b0, per[8]}, per[7:0], {4'b0, ar[11:8]}, ar[7:0]};
        foreach (code_q[k]) f.push_back({5'b0, code_q[k]});
        f.push_back(ref_csum(f));
        code_q.delete();
        got.delete();
        exp_q = f;
        if (poke) begin
            @(posedge clk);
            #1;
            code_valid = 1'b1; contour_done = 1'b1;
            code_in = 3'($urandom); perimeter = 9'($urandom);
            @(posedge clk);
            #1;
            code_valid = 1'b0; contour_done = 1'b0;
            m_ovf = 1'b1;
        end
        for (i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            if (abort_at != 0 && got.size() >= abort_at) break;
            @(posedge clk);
            #1;
        end
        if (i == 400) begin
            check("frame_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic push_basic();
        push_code(3'd0); push_code(3'd2); push_code(3'd4); push_code(3'd6);
    endtask

    task automatic check_basic(input string tag);
        check({tag, "_len"}, got.size(), 12);
        for (int i = 0; i < 11 && i < got.size(); i++) check({tag, "_byte"}, got[i], lit_basic[i]);
`ifndef CHAIN_CODE_FRAMER_CRC8_EN
        if (got.size() == 12) check({tag, "_xor"}, got[11], lit_basic[11]);
`endif
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        check("por_tx_data", tx_data, 0);
        check("por_tx_valid", tx_valid, 0);
        check("por_busy", busy, 0);
        check("por_overflow", overflow, 0);
        check("por_len_err", len_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        fork
            monitor_loop();
            ready_loop();
        join_none

        // Basic frame, ready held high.
        ready_mode = 0;
        @(posedge clk); #1;
        push_basic();
        send_frame(6'd5, 6'd3, 9'd4, 12'd1, 1'b0, 3'd0, 1'b0, 0);
        check_basic("basic");
        check("basic_len_err", len_err, 0);

        // Backpressure.
        ready_mode = 1;
        push_basic();
        send_frame(6'd5, 6'd3, 9'd4, 12'd1, 1'b0, 3'd0, 1'b0, 0);
        check_basic("bp");

        // Empty contour.
        ready_mode = 0;
        send_frame(6'd0, 6'd0, 9'd0, 12'd0, 1'b0, 3'd0, 1'b0, 0);
        check("empty_len", got.size(), 8);
        for (int i = 0; i < got.size(); i++) check("empty_byte", got[i], (i == 0) ? 8'hA5 : 8'h00);
        check("empty_busy", busy, 0);

        // Overflow with a 4-deep FIFO.
        do_reset();
        for (int i = 0; i < 6; i++) push_code(3'(i));
        send_frame(6'd1, 6'd2, 9'd6, 12'd9, 1'b0, 3'd0, 1'b0, 0);
        check("ovf_flag", overflow, 1);
        check("ovf_len_err", len_err, 1);
        check("ovf_frame_len", got.size(), 12);

        // Reset after the 9th byte.
        do_reset();
        push_basic();
        send_frame(6'd5, 6'd3, 9'd4, 12'd1, 1'b0, 3'd0, 1'b0, 9);
        check("abort_got", got.size(), 9);
        do_reset();
        push_basic();
        send_frame(6'd5, 6'd3, 9'd4, 12'd1, 1'b0, 3'd0, 1'b0, 0);
        check_basic("after_abort");

        // Randomised frames.
        for (int n = 0; n < 60; n++) begin
            int    ncodes;
            logic  same;
            logic [8:0] per;
            if ($urandom_range(7, 0) == 0) do_reset();
            ready_mode = $urandom_range(2, 0);
            ncodes = $urandom_range(6, 0);
            same   = (ncodes > 0) && ($urandom_range(1, 0) == 1);
            for (int k = 0; k < ncodes - (same ? 1 : 0); k++) begin
                push_code(3'($urandom));
                if ($urandom_range(3, 0) == 0) begin
                    @(posedge clk); #1;
                end
            end
            per = ($urandom_range(3, 0) != 0) ? 9'(ncodes) : 9'($urandom);
            send_frame(6'($urandom), 6'($urandom), per, 12'($urandom), same, 3'($urandom),
                       $urandom_range(3, 0) == 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
